// File: rtl/and16_serial.sv
// Bit-serial AND: one result bit per clock, LSB first, with valid/ready on both sides.
// Optional early finish on an all-zero operand: define AND16_SERIAL_ZERO_SKIP_EN.
module and16_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state and datapath update for the serial AND sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in0;
                    b_d     = in1;
                    out_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
`ifdef AND16_SERIAL_ZERO_SKIP_EN
                // Remaining result bits are already zero once either operand runs out of ones.
                if ((a_q == '0) || (b_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    out_d[cnt_q] = a_q[0] & b_q[0];
                    a_d          = a_q >> 1'b1;
                    b_d          = b_q >> 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`else
                out_d[cnt_q] = a_q[0] & b_q[0];
                a_d          = a_q >> 1'b1;
                b_d          = b_q >> 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out       = out_q;

endmodule

// File: tb/tb_and16_serial.sv
// Directed self-checking bench for and16_serial; latency expectations follow
// the AND16_SERIAL_ZERO_SKIP_EN build setting.
module tb_and16_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    and16_serial #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to out_valid.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef AND16_SERIAL_ZERO_SKIP_EN
        for (int k = 0; k < 16; k++) begin
            if (((a >> k) == 16'h0000) || ((b >> k) == 16'h0000)) return k + 1;
        end
        return 16;
`else
        return 16;
`endif
    endfunction

    // Present one operand pair, accept it, and wait (bounded) for the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out);
        int lat;
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in0      = ~a;
        in1      = ~b;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat(a, b)));
        check({tag, " out"}, 32'(out), 32'(exp_out));
        check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int saw_valid;

        // Reset with a pending request: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in0       = 16'hFFFF;
        in1       = 16'hFFFF;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out", 32'(out), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check("post-reset busy", 32'(busy), 32'd0);

        // Basic operation with immediate consumer.
        out_ready = 1'b1;
        run_op("f0f0&ff00", 16'hF0F0, 16'hFF00, 16'hF000);
        @(posedge clk);
        #1;
        check("f0f0 taken in_ready", 32'(in_ready), 32'd1);
        check("f0f0 taken out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: result held stable for 5 cycles.
        out_ready = 1'b0;
        run_op("ffff&ffff", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold out", 32'(out), 32'hFFFF);
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        check("release out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of an operation at cnt=7.
        in0      = 16'hAAAA;
        in1      = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid-op busy before reset", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort out", 32'(out), 32'h0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) saw_valid++;
        end
        check("abort no result", 32'(saw_valid), 32'd0);

        // Back-to-back: second accept one cycle after the first result is taken.
        out_ready = 1'b1;
        run_op("1234&00ff", 16'h1234, 16'h00FF, 16'h0034);
        @(posedge clk);
        #1;
        check("b2b in_ready one cycle after take", 32'(in_ready), 32'd1);
        run_op("abcd&ffff", 16'hABCD, 16'hFFFF, 16'hABCD);
        @(posedge clk);
        #1;

        // Zero-operand cases: latency depends on the build.
        run_op("0000&ffff", 16'h0000, 16'hFFFF, 16'h0000);
        @(posedge clk);
        #1;
        run_op("0001&ffff", 16'h0001, 16'hFFFF, 16'h0001);
        @(posedge clk);
        #1;
        check("final in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
